ccu_snoop_responder: RTL and testbench
======================================

Name: ccu_snoop_responder

Overview:
- Snoop-side responder at each cached master; the other end of the CCU snoop crossbar.
- Accepts AC snoop requests, looks up the local cache tag/state array, and returns the CR response.
- For hits that transfer data, streams the cacheline on CD and commands the local state update (clean/share/invalidate).
- Processes one snoop at a time, strictly in order.

Parameters:
- ADDR_WIDTH, 64, AC address width.
- DATA_WIDTH, 64, CD data width; must be a power of 2 and at least 32.
- CACHELINE_BYTES, 64, line size. BEATS = CACHELINE_BYTES*8/DATA_WIDTH (default 8); BLOCK_OFFSET = log2(CACHELINE_BYTES).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- ac_valid_i / ac_ready_o  in/out  1  AC handshake.
- ac_addr_i  in  ADDR_WIDTH  snoop address.
- ac_snoop_i  in  4  ACSNOOP.
- ac_prot_i  in  3  ACPROT; registered, not used internally.
- cr_valid_o / cr_ready_i  out/in  1  CR handshake.
- cr_resp_o  out  5  {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
- cd_valid_o / cd_ready_i  out/in  1  CD handshake.
- cd_data_o  out  DATA_WIDTH  CD data.
- cd_last_o  out  1  CD last beat.
- lookup_req_o  out  1  tag lookup request.
- lookup_addr_o  out  ADDR_WIDTH  line-aligned lookup address.
- lookup_hit_i, lookup_dirty_i, lookup_unique_i  in  1 each  lookup result; valid exactly 1 cycle after lookup_req_o.
- data_req_o  out  1  data array read request.
- data_addr_o  out  ADDR_WIDTH  line base + beat*DATA_WIDTH/8.
- data_rdata_i  in  DATA_WIDTH  read data; valid 1 cycle after data_req_o.
- upd_valid_o / upd_ready_i  out/in  1  state update handshake.
- upd_addr_o  out  ADDR_WIDTH  line address.
- upd_op_o  out  2  update op: 01 clean-shared, 10 invalidate, 11 shared-keep-dirty.

Behaviour:
- Reset: FSM=IDLE. ac_ready_o=1; all other outputs 0, including cr_valid_o, cd_valid_o, upd_valid_o, lookup_req_o, data_req_o. Beat counter=0.
- Async reset mid-transaction aborts the snoop; no partial CR/CD/update is issued afterwards.
- Transitions:
  - IDLE: ac_ready_o=1. On AC handshake, register addr/snoop/prot -> LOOKUP.
  - LOOKUP: lookup_req_o=1 for 1 cycle -> EVAL.
  - EVAL: register hit/dirty/unique; compute resp, op and dt -> RESP.
  - RESP: hold cr_valid_o and cr_resp_o stable until cr_ready_i. Then dt=1 -> RD; else op!=00 -> UPD; else IDLE.
  - RD: data_req_o=1 for beat counter k -> SEND.
  - SEND: cd_valid_o=1 with the registered beat, held until cd_ready_i. cd_last_o=1 when k=BEATS-1. On handshake: last -> UPD if op!=00, else IDLE; not last -> k++, back to RD.
  - UPD: upd_valid_o held until upd_ready_i -> IDLE.
- AC is never accepted outside IDLE.
- Minimum latency: AC accept to cr_valid_o is 3 cycles. Data rate is 2 cycles/beat.
- Response rules: miss -> resp=0, op=00, dt=0. Hit responses:
  - ReadOnce 0000: DT=1, IsShared=1, op=00.
  - ReadShared 0001 and ReadNotSharedDirty 0011: DT=1, IsShared=1, PassDirty=dirty, op=01.
  - ReadClean 0010: DT=1, IsShared=1, PassDirty=0, op=11 if dirty else 01.
  - ReadUnique 0111: DT=1, PassDirty=dirty, op=10.
  - CleanInvalid 1001: DT=dirty, PassDirty=dirty, op=10.
  - CleanShared 1000: DT=dirty, PassDirty=dirty, IsShared=1, op=01 if dirty else 00.
  - MakeInvalid 1101: DT=0, op=10.
  - WasUnique=unique on any hit.
  - Any other encoding, hit or miss: Error=1, all other bits 0, op=00.
- Beat order is 0..BEATS-1 from the line base, matching the CCU's beat-drop logic. Beat counter wraps modulo BEATS.
- Dirty data passes on CD only via PassDirty; the responder never writes memory.

Optional Feature:
- Macro: CCU_SNOOP_RESP_CRITICAL_WORD_EN.
- Defined: the first beat is ac_addr_i[BLOCK_OFFSET-1:log2(DATA_WIDTH/8)] and the order wraps modulo BEATS. cd_last_o asserts on the BEATS-th beat sent.
- Undefined: beat 0 first; the critical-word address bits are ignored.

Test Plan:
- ReadShared 0001, addr 0x1000, hit dirty unique -> cr_resp_o=0b11101; 8 CD beats from data_addr 0x1000..0x1038; cd_last_o on the 8th beat; upd_op_o=01 at addr 0x1000.
- ReadUnique 0111, miss -> cr_resp_o=0; no CD, no update; ac_ready_o back to 1 one cycle after CR handshake.
- CleanInvalid 1001, hit clean -> cr_resp_o=0b10000; no CD; upd_op_o=10.
- ACSNOOP 0101 -> cr_resp_o=0b00010; no CD, no update.
- cr_ready_i low 5 cycles, then cd_ready_i toggling every cycle -> CR/CD valid and data stable while stalled; 8 beats delivered in order; no AC accepted until IDLE.
- rst_i pulsed during SEND at beat 3 -> all valids 0 in the same cycle; ac_ready_o=1 after release; next snoop restarts at beat 0 (macro on, addr 0x1028: beats 5,6,7,0..4).

Source files
------------

// File: rtl/ccu_snoop_responder.sv
// Snoop-side responder: accepts AC snoops, looks up local tag state, answers on CR and streams
// the line on CD. Define CCU_SNOOP_RESP_CRITICAL_WORD_EN to send the addressed beat first.
module ccu_snoop_responder #(
    parameter int unsigned ADDR_WIDTH      = 64,
    parameter int unsigned DATA_WIDTH      = 64,
    parameter int unsigned CACHELINE_BYTES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ac_valid_i,
    output logic                  ac_ready_o,
    input  logic [ADDR_WIDTH-1:0] ac_addr_i,
    input  logic [3:0]            ac_snoop_i,
    input  logic [2:0]            ac_prot_i,
    output logic                  cr_valid_o,
    input  logic                  cr_ready_i,
    output logic [4:0]            cr_resp_o,
    output logic                  cd_valid_o,
    input  logic                  cd_ready_i,
    output logic [DATA_WIDTH-1:0] cd_data_o,
    output logic                  cd_last_o,
    output logic                  lookup_req_o,
    output logic [ADDR_WIDTH-1:0] lookup_addr_o,
    input  logic                  lookup_hit_i,
    input  logic                  lookup_dirty_i,
    input  logic                  lookup_unique_i,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    input  logic [DATA_WIDTH-1:0] data_rdata_i,
    output logic                  upd_valid_o,
    input  logic                  upd_ready_i,
    output logic [ADDR_WIDTH-1:0] upd_addr_o,
    output logic [1:0]            upd_op_o
);

    localparam int unsigned BEATS        = CACHELINE_BYTES * 8 / DATA_WIDTH;
    localparam int unsigned BLOCK_OFFSET = $clog2(CACHELINE_BYTES);
    localparam int unsigned WORD_OFFSET  = $clog2(DATA_WIDTH / 8);
    localparam int unsigned BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_CNT = BEAT_W'(BEATS - 1);

    localparam logic [3:0] SNP_READ_ONCE      = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED    = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN     = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD       = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE    = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED   = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID  = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID   = 4'b1101;

    localparam logic [1:0] OP_NONE       = 2'b00;
    localparam logic [1:0] OP_CLEAN_SHR  = 2'b01;
    localparam logic [1:0] OP_INVALIDATE = 2'b10;
    localparam logic [1:0] OP_SHR_DIRTY  = 2'b11;

    // cr_resp_o bit positions
    localparam int unsigned R_DT  = 0;
    localparam int unsigned R_ERR = 1;
    localparam int unsigned R_PD  = 2;
    localparam int unsigned R_IS  = 3;
    localparam int unsigned R_WU  = 4;

    typedef enum logic [2:0] {
        StIdle, StLookup, StEval, StResp, StRd, StSend, StUpd
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            snoop_q;
    logic [2:0]            prot_q;
    logic [4:0]            resp_q, resp_eval;
    logic [1:0]            op_q, op_eval;
    logic [BEAT_W-1:0]     cnt_q, cnt_d;
    logic                  fresh_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [BEAT_W-1:0]     start_beat, beat;
    logic                  unused_bits;

    assign line_addr = addr_q & ~ADDR_WIDTH'(CACHELINE_BYTES - 1);

`ifdef CCU_SNOOP_RESP_CRITICAL_WORD_EN
    assign start_beat = addr_q[BLOCK_OFFSET-1:WORD_OFFSET];
`else
    assign start_beat = '0;
`endif

    // cnt_q counts beats sent; the array beat is offset from the first beat and wraps
    assign beat        = cnt_q + start_beat;
    assign unused_bits = ^{prot_q, addr_q[BLOCK_OFFSET-1:0]};

    always_comb begin
        resp_eval = '0;
        op_eval   = OP_NONE;
        case (snoop_q)
            SNP_READ_ONCE: begin
                resp_eval[R_DT] = 1'b1;
                resp_eval[R_IS] = 1'b1;
            end
            SNP_READ_SHARED, SNP_READ_NSD: begin
                resp_eval[R_DT] = 1'b1;
                resp_eval[R_IS] = 1'b1;
                resp_eval[R_PD] = lookup_dirty_i;
                op_eval         = OP_CLEAN_SHR;
            end
            SNP_READ_CLEAN: begin
                resp_eval[R_DT] = 1'b1;
                resp_eval[R_IS] = 1'b1;
                op_eval         = lookup_dirty_i ? OP_SHR_DIRTY : OP_CLEAN_SHR;
            end
            SNP_READ_UNIQUE: begin
                resp_eval[R_DT] = 1'b1;
                resp_eval[R_PD] = lookup_dirty_i;
                op_eval         = OP_INVALIDATE;
            end
            SNP_CLEAN_INVALID: begin
                resp_eval[R_DT] = lookup_dirty_i;
                resp_eval[R_PD] = lookup_dirty_i;
                op_eval         = OP_INVALIDATE;
            end
            SNP_CLEAN_SHARED: begin
                resp_eval[R_DT] = lookup_dirty_i;
                resp_eval[R_PD] = lookup_dirty_i;
                resp_eval[R_IS] = 1'b1;
                op_eval         = lookup_dirty_i ? OP_CLEAN_SHR : OP_NONE;
            end
            SNP_MAKE_INVALID: begin
                op_eval = OP_INVALIDATE;
            end
            default: begin
                resp_eval[R_ERR] = 1'b1;
            end
        endcase
        // Unsupported encodings report Error regardless of the lookup
        if (!resp_eval[R_ERR]) begin
            if (!lookup_hit_i) begin
                resp_eval = '0;
                op_eval   = OP_NONE;
            end else begin
                resp_eval[R_WU] = lookup_unique_i;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ac_ready_o   = 1'b0;
        lookup_req_o = 1'b0;
        cr_valid_o   = 1'b0;
        data_req_o   = 1'b0;
        cd_valid_o   = 1'b0;
        upd_valid_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                ac_ready_o = 1'b1;
                if (ac_valid_i) begin
                    cnt_d   = '0;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                lookup_req_o = 1'b1;
                state_d      = StEval;
            end
            StEval: state_d = StResp;
            StResp: begin
                cr_valid_o = 1'b1;
                if (cr_ready_i) begin
                    if (resp_q[R_DT])         state_d = StRd;
                    else if (op_q != OP_NONE) state_d = StUpd;
                    else                      state_d = StIdle;
                end
            end
            StRd: begin
                data_req_o = 1'b1;
                state_d    = StSend;
            end
            StSend: begin
                cd_valid_o = 1'b1;
                if (cd_ready_i) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = (op_q != OP_NONE) ? StUpd : StIdle;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = StRd;
                    end
                end
            end
            StUpd: begin
                upd_valid_o = 1'b1;
                if (upd_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            snoop_q <= '0;
            prot_q  <= '0;
            resp_q  <= '0;
            op_q    <= OP_NONE;
            cnt_q   <= '0;
            fresh_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fresh_q <= (state_q == StRd);
            if (state_q == StIdle && ac_valid_i) begin
                addr_q  <= ac_addr_i;
                snoop_q <= ac_snoop_i;
                prot_q  <= ac_prot_i;
            end
            if (state_q == StEval) begin
                resp_q <= resp_eval;
                op_q   <= op_eval;
            end
            // Read data arrives in the first SEND cycle; hold it for stalled beats
            if (state_q == StSend && fresh_q) data_q <= data_rdata_i;
        end
    end

    assign lookup_addr_o = lookup_req_o ? line_addr : '0;
    assign data_addr_o   = data_req_o ? (line_addr | (ADDR_WIDTH'(beat) << WORD_OFFSET)) : '0;
    assign cr_resp_o     = cr_valid_o ? resp_q : '0;
    assign cd_data_o     = cd_valid_o ? (fresh_q ? data_rdata_i : data_q) : '0;
    assign cd_last_o     = cd_valid_o && (cnt_q == LAST_CNT);
    assign upd_addr_o    = upd_valid_o ? line_addr : '0;
    assign upd_op_o      = upd_valid_o ? op_q : OP_NONE;

endmodule

// File: tb/tb_ccu_snoop_responder.sv
// Directed bench for ccu_snoop_responder with CR/CD scoreboards and a 1-cycle data array model.
module tb_ccu_snoop_responder;

    localparam int unsigned BEATS = 8;
    localparam int unsigned CL    = 64;
    localparam int unsigned WB    = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ac_valid_i, ac_ready_o;
    logic [63:0] ac_addr_i;
    logic [3:0]  ac_snoop_i;
    logic [2:0]  ac_prot_i;
    logic        cr_valid_o, cr_ready_i;
    logic [4:0]  cr_resp_o;
    logic        cd_valid_o, cd_ready_i, cd_last_o;
    logic [63:0] cd_data_o;
    logic        lookup_req_o, lookup_hit_i, lookup_dirty_i, lookup_unique_i;
    logic [63:0] lookup_addr_o;
    logic        data_req_o;
    logic [63:0] data_addr_o;
    logic [63:0] data_rdata_i = '0;
    logic        upd_valid_o, upd_ready_i;
    logic [63:0] upd_addr_o;
    logic [1:0]  upd_op_o;

    int vectors = 0;
    int miscompares = 0;

    logic [6:0]  cr_q[$];
    logic [63:0] cd_q[$];
    logic [63:0] addr_q[$];

    always #5 clk_i = ~clk_i;

    ccu_snoop_responder dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o), .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i), .ac_prot_i(ac_prot_i),
        .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
        .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
        .cd_last_o(cd_last_o),
        .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o),
        .lookup_hit_i(lookup_hit_i), .lookup_dirty_i(lookup_dirty_i),
        .lookup_unique_i(lookup_unique_i),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_rdata_i(data_rdata_i),
        .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_addr_o(upd_addr_o),
        .upd_op_o(upd_op_o)
    );

    function automatic logic [63:0] pattern(input logic [63:0] a);
        return {a[31:0] ^ 32'hC0DE_5EED, a[31:0] + 32'h1234_5678};
    endfunction

    // Data array: read data one cycle after the request
    always @(posedge clk_i) if (data_req_o) data_rdata_i <= pattern(data_addr_o);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference response table: r = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
    function automatic void model(input logic [3:0] s, input logic h, d, u,
                                  output logic [4:0] r, output logic [1:0] op);
        logic is, pd, er, dt;
        is = 0; pd = 0; er = 0; dt = 0; op = 2'b00;
        case (s)
            4'b0000:          begin dt = 1; is = 1; end
            4'b0001, 4'b0011: begin dt = 1; is = 1; pd = d; op = 2'b01; end
            4'b0010:          begin dt = 1; is = 1; op = d ? 2'b11 : 2'b01; end
            4'b0111:          begin dt = 1; pd = d; op = 2'b10; end
            4'b1001:          begin dt = d; pd = d; op = 2'b10; end
            4'b1000:          begin dt = d; pd = d; is = 1; op = d ? 2'b01 : 2'b00; end
            4'b1101:          op = 2'b10;
            default:          er = 1;
        endcase
        if (er) begin
            r = 5'b00010; op = 2'b00;
        end else if (!h) begin
            r = 5'b00000; op = 2'b00;
        end else begin
            r = {u, is, pd, 1'b0, dt};
        end
    endfunction

    task automatic run_snoop(input string nm, input logic [3:0] snp, input logic [63:0] addr,
                             input logic hit, dirty, uniq, input int cr_stall,
                             input bit cd_toggle, input int abort_at);
        logic [4:0]  resp;
        logic [1:0]  op;
        logic [6:0]  exp_cr;
        logic [63:0] line, a;
        int first, n;
        bit aborted;
        aborted = 0;
        model(snp, hit, dirty, uniq, resp, op);
        line  = addr & ~64'(CL - 1);
        first = 0;
`ifdef CCU_SNOOP_RESP_CRITICAL_WORD_EN
        first = int'((addr % CL) / WB);
`endif
        cr_q.push_back({op, resp});
        if (resp[0]) begin
            for (int i = 0; i < BEATS; i++) begin
                a = line + 64'(((first + i) % BEATS) * WB);
                addr_q.push_back(a);
                cd_q.push_back(pattern(a));
            end
        end
        lookup_hit_i = hit; lookup_dirty_i = dirty; lookup_unique_i = uniq;

        @(negedge clk_i);
        check({nm, " ac_ready_idle"}, ac_ready_o, 1);
        ac_valid_i = 1; ac_addr_i = addr; ac_snoop_i = snp; ac_prot_i = 3'b010;
        @(negedge clk_i);
        ac_valid_i = 0;
        check({nm, " ac_ready_busy"}, ac_ready_o, 0);
        check({nm, " lookup_req"}, lookup_req_o, 1);
        check({nm, " lookup_addr"}, lookup_addr_o, line);
        n = 1;
        while (!cr_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check({nm, " cr_latency"}, 64'(n), 3);
        for (int s = 0; s < cr_stall; s++) begin
            check({nm, " cr_hold_valid"}, cr_valid_o, 1);
            check({nm, " cr_hold_resp"}, cr_resp_o, cr_q[0][4:0]);
            check({nm, " ac_blocked"}, ac_ready_o, 0);
            @(negedge clk_i);
        end
        exp_cr = cr_q.pop_front();
        check({nm, " cr_valid"}, cr_valid_o, 1);
        check({nm, " cr_resp"}, cr_resp_o, exp_cr[4:0]);
        cr_ready_i = 1;
        @(negedge clk_i);
        cr_ready_i = 0;

        if (resp[0]) begin
            for (int i = 0; i < BEATS && !aborted; i++) begin
                check({nm, " data_req"}, data_req_o, 1);
                check({nm, " data_addr"}, data_addr_o, addr_q.pop_front());
                @(negedge clk_i);
                if (i == abort_at) begin
                    rst_i = 1;
                    #1;
                    check({nm, " rst_cd_valid"}, cd_valid_o, 0);
                    check({nm, " rst_cr_valid"}, cr_valid_o, 0);
                    check({nm, " rst_upd_valid"}, upd_valid_o, 0);
                    check({nm, " rst_data_req"}, data_req_o, 0);
                    @(negedge clk_i);
                    rst_i = 0;
                    @(negedge clk_i);
                    check({nm, " rst_ac_ready"}, ac_ready_o, 1);
                    check({nm, " rst_cd_idle"}, cd_valid_o, 0);
                    cd_q.delete();
                    addr_q.delete();
                    aborted = 1;
                end else begin
                    if (cd_toggle) begin
                        check({nm, " cd_hold_valid"}, cd_valid_o, 1);
                        check({nm, " cd_hold_data"}, cd_data_o, cd_q[0]);
                        check({nm, " cd_ac_blocked"}, ac_ready_o, 0);
                        @(negedge clk_i);
                    end
                    check({nm, " cd_valid"}, cd_valid_o, 1);
                    check({nm, " cd_data"}, cd_data_o, cd_q.pop_front());
                    check({nm, " cd_last"}, cd_last_o, (i == BEATS - 1) ? 1 : 0);
                    cd_ready_i = 1;
                    @(negedge clk_i);
                    cd_ready_i = 0;
                end
            end
        end

        if (!aborted) begin
            if (exp_cr[6:5] != 2'b00) begin
                check({nm, " upd_valid"}, upd_valid_o, 1);
                check({nm, " upd_op"}, upd_op_o, exp_cr[6:5]);
                check({nm, " upd_addr"}, upd_addr_o, line);
                upd_ready_i = 1;
                @(negedge clk_i);
                upd_ready_i = 0;
            end
            check({nm, " end_ac_ready"}, ac_ready_o, 1);
            check({nm, " end_cd_valid"}, cd_valid_o, 0);
            check({nm, " end_upd_valid"}, upd_valid_o, 0);
            check({nm, " end_cr_valid"}, cr_valid_o, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1;
        ac_valid_i = 0; ac_addr_i = '0; ac_snoop_i = '0; ac_prot_i = '0;
        cr_ready_i = 0; cd_ready_i = 0; upd_ready_i = 0;
        lookup_hit_i = 0; lookup_dirty_i = 0; lookup_unique_i = 0;
        repeat (2) @(negedge clk_i);
        check("reset ac_ready", ac_ready_o, 1);
        check("reset cr_valid", cr_valid_o, 0);
        check("reset cd_valid", cd_valid_o, 0);
        check("reset upd_valid", upd_valid_o, 0);
        check("reset lookup_req", lookup_req_o, 0);
        check("reset data_req", data_req_o, 0);
        rst_i = 0;
        @(negedge clk_i);
        check("post-reset ac_ready", ac_ready_o, 1);

        run_snoop("read_shared", 4'b0001, 64'h1000, 1, 1, 1, 0, 0, -1);
        run_snoop("read_unique_miss", 4'b0111, 64'h2040, 0, 0, 0, 0, 0, -1);
        run_snoop("clean_inv_clean", 4'b1001, 64'h3000, 1, 0, 1, 0, 0, -1);
        run_snoop("bad_snoop", 4'b0101, 64'h3040, 1, 1, 1, 0, 0, -1);
        run_snoop("read_once_stall", 4'b0000, 64'h4000, 1, 0, 0, 5, 1, -1);
        run_snoop("read_clean_dirty", 4'b0010, 64'h4100, 1, 1, 0, 0, 0, -1);
        run_snoop("make_invalid", 4'b1101, 64'h4200, 1, 1, 1, 0, 0, -1);
        run_snoop("clean_shared_dirty", 4'b1000, 64'h5018, 1, 1, 0, 1, 1, -1);
        run_snoop("read_shared_abort", 4'b0001, 64'h1028, 1, 0, 0, 0, 0, 3);
        run_snoop("read_shared_retry", 4'b0001, 64'h1028, 1, 0, 0, 0, 0, -1);

        check("cd scoreboard empty", 64'(cd_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
